// File: rtl/traffic_lamp_monitor.sv
// Lamp-protocol monitor for a two-road traffic-light controller: tracks each
// direction's phase and dwell, latches the first violation, counts cycles.
module traffic_lamp_monitor #(
   parameter int CW        = 8,
   parameter int MIN_YLW   = 2,
   parameter int MAX_DWELL = 200
) (
   input  logic       CK,
   input  logic       CLR,
   input  logic       GRN1,
   input  logic       YLW1,
   input  logic       RED1,
   input  logic       GRN2,
   input  logic       YLW2,
   input  logic       RED2,
   input  logic       TEST,
   input  logic       ACK,
   output logic [1:0] PHASE1,
   output logic [1:0] PHASE2,
   output logic       FAULT,
   output logic [2:0] FCODE,
   output logic [7:0] CYCLES
);

   typedef enum logic [1:0] {UNK = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, RED = 2'b11} phase_t;

   logic [2:0]    lamp1_q, lamp2_q;
   logic          vld_q, vld_d;
   phase_t        ph1_q, ph1_d, ph2_q, ph2_d;
   logic [CW-1:0] dw1_q, dw1_d, dw2_q, dw2_d;
   logic          fault_q, fault_d;
   logic [2:0]    fcode_q, fcode_d;
   logic [7:0]    cyc_q, cyc_d;

   logic          ok1, ok2;
   phase_t        dp1, dp2;
   logic          conflict, bad_code, bad_trans, short_ylw, timeout;
   logic [2:0]    code;

   // Lamp vectors are ordered {GRN, YLW, RED}.
   function automatic logic lamp_ok(input logic [2:0] l);
      return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
   endfunction

   function automatic phase_t lamp_ph(input logic [2:0] l);
      case (l)
         3'b100:  return GREEN;
         3'b010:  return YELLOW;
         3'b001:  return RED;
         default: return UNK;
      endcase
   endfunction

   function automatic logic bad_move(input phase_t cur, input logic ok, input phase_t nxt);
      return (cur != UNK) && ok && (nxt != cur) &&
             !((cur == GREEN  && nxt == YELLOW) ||
               (cur == YELLOW && nxt == RED)    ||
               (cur == RED    && nxt == GREEN));
   endfunction

   function automatic logic is_short(input phase_t cur, input logic ok, input phase_t nxt,
                                     input logic [CW-1:0] dw);
      return (cur == YELLOW) && ok && (nxt != YELLOW) && (dw < CW'(MIN_YLW));
   endfunction

   // Evaluated on the dwell the current sample produces, so a timeout shows up
   // with the same two-edge latency as every other fault and fires only once.
   function automatic logic is_timeout(input phase_t ph, input logic [CW-1:0] dw);
      return ((ph == GREEN) || (ph == YELLOW)) && (dw == CW'(MAX_DWELL));
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      ok1   = lamp_ok(lamp1_q);
      ok2   = lamp_ok(lamp2_q);
      dp1   = lamp_ph(lamp1_q);
      dp2   = lamp_ph(lamp2_q);
      vld_d = 1'b1;

      ph1_d = ok1 ? dp1 : ph1_q;
      ph2_d = ok2 ? dp2 : ph2_q;
      dw1_d = (ok1 && dp1 != ph1_q) ? CW'(1) : sat_inc(dw1_q);
      dw2_d = (ok2 && dp2 != ph2_q) ? CW'(1) : sat_inc(dw2_q);

      conflict  = ok1 && ok2 && (dp1 != RED) && (dp2 != RED);
      bad_code  = !ok1 || !ok2;
      bad_trans = bad_move(ph1_q, ok1, dp1) || bad_move(ph2_q, ok2, dp2);
      short_ylw = is_short(ph1_q, ok1, dp1, dw1_q) || is_short(ph2_q, ok2, dp2, dw2_q);
      timeout   = !TEST && (is_timeout(ph1_d, dw1_d) || is_timeout(ph2_d, dw2_d));

      // The all-zero sample held in reset is not a real observation.
      code = 3'd0;
      if (vld_q) begin
         if      (conflict)  code = 3'd1;
         else if (bad_code)  code = 3'd2;
         else if (bad_trans) code = 3'd3;
         else if (short_ylw) code = 3'd4;
         else if (timeout)   code = 3'd5;
      end

      fault_d = fault_q;
      fcode_d = fcode_q;
      if ((code != 3'd0) && (!fault_q || ACK)) begin
         fault_d = 1'b1;
         fcode_d = code;
      end else if (ACK) begin
         fault_d = 1'b0;
         fcode_d = 3'd0;
      end

      cyc_d = cyc_q + 8'((ph1_q == RED) && ok1 && (dp1 == GREEN));
   end

   always_ff @(posedge CK or posedge CLR) begin
      if (CLR) begin
         lamp1_q <= '0;
         lamp2_q <= '0;
         vld_q   <= 1'b0;
         ph1_q   <= UNK;
         ph2_q   <= UNK;
         dw1_q   <= '0;
         dw2_q   <= '0;
         fault_q <= 1'b0;
         fcode_q <= '0;
         cyc_q   <= '0;
      end else begin
         lamp1_q <= {GRN1, YLW1, RED1};
         lamp2_q <= {GRN2, YLW2, RED2};
         vld_q   <= vld_d;
         ph1_q   <= ph1_d;
         ph2_q   <= ph2_d;
         dw1_q   <= dw1_d;
         dw2_q   <= dw2_d;
         fault_q <= fault_d;
         fcode_q <= fcode_d;
         cyc_q   <= cyc_d;
      end
   end

   assign PHASE1 = ph1_q;
   assign PHASE2 = ph2_q;
   assign FAULT  = fault_q;
   assign FCODE  = fcode_q;
   assign CYCLES = cyc_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor: a reference model pushes expected
// outputs per driven step into a queue, popped and compared after the edge.
module tb_traffic_lamp_monitor;

   localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, OFF = 3'b000;
   localparam int MINY = 2, MAXD = 200;

   logic CK = 1'b0, CLR = 1'b1, TEST = 1'b0, ACK = 1'b0;
   logic GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b0, GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b0;
   logic [1:0] PHASE1, PHASE2;
   logic       FAULT;
   logic [2:0] FCODE;
   logic [7:0] CYCLES;

   traffic_lamp_monitor #(.CW(8), .MIN_YLW(MINY), .MAX_DWELL(MAXD)) dut (
      .CK(CK), .CLR(CLR),
      .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
      .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
      .TEST(TEST), .ACK(ACK),
      .PHASE1(PHASE1), .PHASE2(PHASE2),
      .FAULT(FAULT), .FCODE(FCODE), .CYCLES(CYCLES)
   );

   always #5 CK = ~CK;

   typedef struct packed {
      logic [1:0] p1, p2;
      logic       f;
      logic [2:0] c;
      logic [7:0] n;
   } exp_t;
   exp_t sb[$];

   int checks = 0, passed = 0, fails = 0;

   // reference model state
   logic [2:0] ms1, ms2;
   logic       mvld, mf;
   logic [1:0] mp1, mp2;
   int         mdw1, mdw2;
   logic [2:0] mc;
   logic [7:0] mn;

   task automatic m_reset();
      ms1 = 0; ms2 = 0; mvld = 0; mp1 = 0; mp2 = 0;
      mdw1 = 0; mdw2 = 0; mf = 0; mc = 0; mn = 0;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // returns {legal, phase}
   function automatic logic [2:0] mdec(input logic [2:0] l);
      if (l == G) return 3'b101;
      if (l == Y) return 3'b110;
      if (l == R) return 3'b111;
      return 3'b000;
   endfunction

   function automatic logic mbad(input logic [1:0] ph, input logic v, input logic [1:0] p);
      if (ph == 0 || !v || p == ph) return 1'b0;
      return !((ph == 1 && p == 2) || (ph == 2 && p == 3) || (ph == 3 && p == 1));
   endfunction

   task automatic m_edge(input logic [2:0] l1, input logic [2:0] l2);
      logic [2:0] d1, d2, c;
      logic [1:0] np1, np2;
      int nd1, nd2;
      exp_t e;
      d1 = mdec(ms1);
      d2 = mdec(ms2);
      np1 = d1[2] ? d1[1:0] : mp1;
      np2 = d2[2] ? d2[1:0] : mp2;
      nd1 = (d1[2] && d1[1:0] != mp1) ? 1 : (mdw1 == 255 ? 255 : mdw1 + 1);
      nd2 = (d2[2] && d2[1:0] != mp2) ? 1 : (mdw2 == 255 ? 255 : mdw2 + 1);
      c = 0;
      if (mvld) begin
         if (!TEST && (((np1 == 1 || np1 == 2) && nd1 == MAXD) ||
                       ((np2 == 1 || np2 == 2) && nd2 == MAXD))) c = 5;
         if ((mp1 == 2 && d1[2] && d1[1:0] != 2 && mdw1 < MINY) ||
             (mp2 == 2 && d2[2] && d2[1:0] != 2 && mdw2 < MINY)) c = 4;
         if (mbad(mp1, d1[2], d1[1:0]) || mbad(mp2, d2[2], d2[1:0])) c = 3;
         if (!d1[2] || !d2[2]) c = 2;
         if (d1[2] && d2[2] && d1[1:0] != 3 && d2[1:0] != 3) c = 1;
      end
      if (c != 0 && (!mf || ACK)) begin
         mf = 1; mc = c;
      end else if (ACK) begin
         mf = 0; mc = 0;
      end
      if (mp1 == 3 && d1 == 3'b101) mn = mn + 1;
      mp1 = np1; mp2 = np2; mdw1 = nd1; mdw2 = nd2;
      ms1 = l1; ms2 = l2; mvld = 1;
      e.p1 = mp1; e.p2 = mp2; e.f = mf; e.c = mc; e.n = mn;
      sb.push_back(e);
   endtask

   task automatic step(input logic [2:0] l1, input logic [2:0] l2);
      exp_t e;
      {GRN1, YLW1, RED1} = l1;
      {GRN2, YLW2, RED2} = l2;
      m_edge(l1, l2);
      @(posedge CK);
      #1;
      e = sb.pop_front();
      chk("phase1", 8'(PHASE1), 8'(e.p1));
      chk("phase2", 8'(PHASE2), 8'(e.p2));
      chk("fault",  8'(FAULT),  8'(e.f));
      chk("fcode",  8'(FCODE),  8'(e.c));
      chk("cycles", CYCLES,     e.n);
   endtask

   task automatic rep(input int n, input logic [2:0] l1, input logic [2:0] l2);
      for (int i = 0; i < n; i++) step(l1, l2);
   endtask

   int ncyc;

   initial begin
      m_reset();
      {GRN1, YLW1, RED1} = G;
      {GRN2, YLW2, RED2} = R;
      #12;
      chk("rst_fault", 8'(FAULT), 8'd0);
      chk("rst_phase1", 8'(PHASE1), 8'd0);
      chk("rst_cycles", CYCLES, 8'd0);
      CLR = 1'b0;

      // legal cycle: dir1 G5 Y3 R8, dir2 R9 G4 Y3, then dir1 R->G
      rep(5, G, R); rep(3, Y, R); step(R, R);
      rep(4, R, G); rep(3, R, Y); step(G, R);
      rep(2, G, R);
      chk("legal_cycles", CYCLES, 8'd1);
      chk("legal_nofault", 8'(FAULT), 8'd0);

      // conflict from dir1 RED, then illegal code must not overwrite FCODE
      rep(2, Y, R); rep(2, R, R);
      step(G, G); step(OFF, G);
      chk("conflict_fault", 8'(FAULT), 8'd1);
      chk("conflict_code", 8'(FCODE), 8'd1);
      step(G, G);
      chk("sticky_code", 8'(FCODE), 8'd1);
      rep(2, G, Y); rep(2, G, R);
      ACK = 1'b1; step(G, R); ACK = 1'b0;
      chk("ack_clear", 8'(FAULT), 8'd0);

      // short yellow, then direct GREEN->RED
      step(Y, R); rep(2, R, R);
      chk("short_ylw", 8'(FCODE), 8'd4);
      ACK = 1'b1; step(R, R); ACK = 1'b0;
      step(G, R); rep(2, R, R);
      chk("bad_trans", 8'(FCODE), 8'd3);
      chk("bad_trans_ph1", 8'(PHASE1), 8'd3);
      ACK = 1'b1; step(R, R); ACK = 1'b0;

      // timeout with TEST=0
      rep(200, G, R);
      chk("pre_timeout", 8'(FAULT), 8'd0);
      step(G, R);
      chk("timeout_fault", 8'(FAULT), 8'd1);
      chk("timeout_code", 8'(FCODE), 8'd5);
      ACK = 1'b1; step(G, R); ACK = 1'b0;
      rep(2, Y, R); rep(3, R, R);

      // TEST suppresses timeout; saturated dwell never re-fires
      TEST = 1'b1;
      rep(300, G, R);
      chk("test_nofault", 8'(FAULT), 8'd0);
      TEST = 1'b0;
      rep(200, G, R);
      chk("sat_nofault", 8'(FAULT), 8'd0);
      rep(2, Y, R); rep(3, R, R);

      // dir2 lamps dark for one cycle
      step(R, OFF); step(R, R);
      chk("dark_code", 8'(FCODE), 8'd2);
      chk("dark_ph2", 8'(PHASE2), 8'd3);
      ACK = 1'b1; step(R, R); ACK = 1'b0;

      // ACK coinciding with a new fault: new fault wins
      step(R, OFF); step(R, R); step(R, Y);
      ACK = 1'b1; step(R, Y); ACK = 1'b0;
      chk("ack_newfault", 8'(FAULT), 8'd1);
      chk("ack_newcode", 8'(FCODE), 8'd3);
      step(R, R);
      ACK = 1'b1; step(R, R); ACK = 1'b0;
      chk("ack_clear2", 8'(FAULT), 8'd0);

      // legal dir1 cycles until the counter wraps
      ncyc = 256 - int'(mn);
      for (int i = 0; i < ncyc; i++) begin
         rep(2, G, R); rep(2, Y, R); rep(2, R, R);
      end
      chk("cycles_wrap", CYCLES, 8'd0);

      // asynchronous clear mid-phase
      rep(3, G, R);
      @(posedge CK);
      #3 CLR = 1'b1;
      #1;
      chk("aclr_fault", 8'(FAULT), 8'd0);
      chk("aclr_fcode", 8'(FCODE), 8'd0);
      chk("aclr_ph1", 8'(PHASE1), 8'd0);
      chk("aclr_ph2", 8'(PHASE2), 8'd0);
      m_reset();
      #12 CLR = 1'b0;
      rep(3, G, R);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
